// File: rtl/seq_booth_multiplier.sv
// Sequential radix-4 Booth multiplier with run-time signed/unsigned mode.
// Operands are taken through a valid/ready handshake. Two multiplier bits are
// retired per cycle. The registered 2*WIDTH-bit product is returned through
// a second valid/ready handshake.
// Optional feature macro ZERO_BYPASS_EN: when defined, a zero operand skips
// the iterations and completes on the accept edge with p = 0.
module seq_booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               signed_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);

    localparam int ITER = WIDTH / 2 + 1;      // Booth iterations per operation
    localparam int CW   = $clog2(ITER + 1);   // iteration counter width
    localparam int XW   = WIDTH + 2;          // extended operand width
    localparam int AW   = WIDTH + 3;          // accumulator width (holds +-2A)

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [XW-1:0]      mcand_q, mcand_d;
    logic [XW-1:0]      mult_q, mult_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic               guard_q, guard_d;
    logic [2*WIDTH-1:0] p_q, p_d;

    logic               accept;
    logic [XW-1:0]      a_ext, b_ext;
    logic [AW-1:0]      mcand_w, pp, sum, acc_shift;
    logic [XW-1:0]      mult_shift;
    logic [2*WIDTH-1:0] product_lo;

    assign accept  = in_valid && in_ready;
    assign a_ext   = signed_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    assign b_ext   = signed_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
    assign mcand_w = {mcand_q[XW-1], mcand_q};

    // Booth radix-4 recoding of the current multiplier triplet into a partial product.
    always_comb begin
        unique case ({mult_q[1:0], guard_q})
            3'b001, 3'b010: pp = mcand_w;
            3'b011:         pp = {mcand_w[AW-2:0], 1'b0};
            3'b100:         pp = -{mcand_w[AW-2:0], 1'b0};
            3'b101, 3'b110: pp = -mcand_w;
            default:        pp = '0;
        endcase
    end

    // One iteration: add, then arithmetic-shift {acc, mult, guard} right by two.
    assign sum        = acc_q + pp;
    assign acc_shift  = {{2{sum[AW-1]}}, sum[AW-1:2]};
    assign mult_shift = {sum[1:0], mult_q[XW-1:2]};
    // After the last shift the multiplier register holds the low XW product bits.
    assign product_lo = {acc_shift[WIDTH-3:0], mult_shift};

    // Next-state and datapath control for the IDLE/CALC/DONE sequence.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        mult_d  = mult_q;
        acc_d   = acc_q;
        guard_d = guard_q;
        p_d     = p_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mcand_d = a_ext;
                    mult_d  = b_ext;
                    acc_d   = '0;
                    guard_d = 1'b0;
                    cnt_d   = '0;
`ifdef ZERO_BYPASS_EN
                    if (a == '0 || b == '0) begin
                        p_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_CALC;
                    end
`else
                    state_d = S_CALC;
`endif
                end
            end
            S_CALC: begin
                acc_d   = acc_shift;
                mult_d  = mult_shift;
                guard_d = mult_q[1];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    p_d     = product_lo;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            mult_q  <= '0;
            acc_q   <= '0;
            guard_q <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            mult_q  <= mult_d;
            acc_q   <= acc_d;
            guard_q <= guard_d;
            p_q     <= p_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign p         = p_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Self-checking bench for seq_booth_multiplier (WIDTH = 32).
// The reference product is plain 64-bit arithmetic on extended operands.
// A single negedge monitor performs every comparison: reset state, handshake
// rules, latency, hold under backpressure and the product itself.
module tb_seq_booth_multiplier;

    localparam int W    = 32;
    localparam int ITER = W / 2 + 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          signed_mode;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] p;
    logic          busy;

    seq_booth_multiplier #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .p           (p),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] prod;
        logic [63:0] lit;
        bit          has_lit;
        int          lat;
        longint      t_acc;
    } exp_t;

    exp_t exp_mem [64];
    int   wr_idx = 0;      // written only by the stimulus process
    int   rd_idx = 0;      // written only by the monitor
    int   checks = 0;
    int   errors = 0;

    logic        prev_rst   = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_hs    = 1'b0;
    logic [63:0] prev_p     = '0;

    // Reference product: extend both operands to 64 bits, multiply mod 2^64.
    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic sm);
        logic [63:0] xe, ye;
        xe = sm ? {{32{x[31]}}, x} : {32'd0, x};
        ye = sm ? {{32{y[31]}}, y} : {32'd0, y};
        return xe * ye;
    endfunction

    // Latency counted in rising edges, the accept edge being the first.
    function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef ZERO_BYPASS_EN
        if (x == 0 || y == 0) return 1;
`endif
        return ITER + 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%h, required 0x%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // The single compare process: samples DUT outputs on every falling edge.
    always @(negedge clk) begin
        if (rst) begin
            if (prev_rst) begin
                check("reset_out_valid", {63'd0, out_valid}, 64'd0);
                check("reset_in_ready",  {63'd0, in_ready},  64'd1);
                check("reset_busy",      {63'd0, busy},      64'd0);
                check("reset_p",         p,                  64'd0);
            end
            prev_rst   <= 1'b1;
            prev_valid <= 1'b0;
            prev_hs    <= 1'b0;
            rd_idx     <= wr_idx;
        end else begin
            check("in_ready_is_not_busy", {63'd0, in_ready}, {63'd0, !busy});
            if (out_valid) check("busy_while_valid", {63'd0, busy}, 64'd1);
            if (prev_hs) begin
                check("valid_drops_after_handshake", {63'd0, out_valid}, 64'd0);
                check("p_kept_after_handshake", p, prev_p);
            end else if (prev_valid) begin
                check("valid_held_without_ready", {63'd0, out_valid}, 64'd1);
                check("p_stable_without_ready", p, prev_p);
            end
            if (out_valid && !prev_valid) begin
                if (rd_idx == wr_idx)
                    check("out_valid_without_pending_op", {63'd0, out_valid}, 64'd0);
                else
                    check("latency",
                          64'(int'(($time - 5 - exp_mem[rd_idx % 64].t_acc) / 10) + 1),
                          64'(exp_mem[rd_idx % 64].lat));
            end
            if (out_valid && out_ready && rd_idx != wr_idx) begin
                check("product_vs_model", p, exp_mem[rd_idx % 64].prod);
                if (exp_mem[rd_idx % 64].has_lit)
                    check("product_vs_literal", p, exp_mem[rd_idx % 64].lit);
                rd_idx <= rd_idx + 1;
            end
            prev_rst   <= 1'b0;
            prev_valid <= out_valid;
            prev_hs    <= out_valid && out_ready;
            prev_p     <= p;
        end
    end

    // Present operands until accepted; record the expectation at the accept edge.
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic sm,
                        input logic [63:0] lit, input bit has_lit);
        int n;
        n = 0;
        a = av; b = bv; signed_mode = sm; in_valid = 1'b1;
        while (in_ready !== 1'b1) begin
            if (n == 200) begin
                $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
                $fatal(1, "stopping: operands never accepted");
            end
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        exp_mem[wr_idx % 64].prod    = model(av, bv, sm);
        exp_mem[wr_idx % 64].lit     = lit;
        exp_mem[wr_idx % 64].has_lit = has_lit;
        exp_mem[wr_idx % 64].lat     = exp_lat(av, bv);
        exp_mem[wr_idx % 64].t_acc   = longint'($time);
        wr_idx++;
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; signed_mode = 1'($urandom);
    endtask

    // Wait for the result, hold off for 'stall' cycles (optionally poking in_valid), then take it.
    task automatic collect(input int stall, input bit poke);
        int n;
        n = 0;
        out_ready = 1'b0;
        while (out_valid !== 1'b1) begin
            if (n == 200) begin
                $display("FAIL result_timeout: out_valid=%b after %0d cycles, required 1", out_valid, n);
                $fatal(1, "stopping: result never produced");
            end
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                in_valid = 1'b1; a = $urandom; b = $urandom; signed_mode = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Directed products with hand-computed results.
        send(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1); collect(0, 1'b0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 1'b1); collect(1, 1'b0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 1'b1); collect(0, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 1'b1); collect(2, 1'b0);

        // Backpressure: ten cycles held in DONE while new operands are offered.
        send(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000, 1'b1); collect(10, 1'b1);
        send(32'h0000_0003, 32'h0000_0004, 1'b0, 64'h0000_0000_0000_000C, 1'b1); collect(0, 1'b0);

        // Reset in the middle of an operation; the aborted result must never appear.
        send(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (25) @(posedge clk);
        #1;

        // Zero operands.
        send(32'h0000_0000, 32'h0000_1234, 1'b0, 64'd0, 1'b1); collect(0, 1'b0);
        send(32'h0000_1234, 32'h0000_0000, 1'b1, 64'd0, 1'b1); collect(1, 1'b0);
        send(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 64'd0, 1'b1); collect(0, 1'b0);

        // Randomised operands and modes with random backpressure.
        for (int k = 0; k < 2000; k++) begin
            send(pick(), pick(), 1'($urandom), 64'd0, 1'b0);
            collect(int'($urandom_range(0, 2)), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
